ppu_pipe: RTL and testbench

Parametrised, pipelined post-processing unit between the PE-array partial-sum path and the output SRAM write port. Accepts one word of `LANES` signed 16-bit accumulators per beat over a valid/ready handshake and applies per-lane masking, optional ReLU, arithmetic-shift requantisation, zero-point add and unsigned clamp. Emits one word of zero-extended 8-bit results per beat at full throughput with backpressure. Keeps a saturating count of clamped lanes for profiling.

---
 rtl/ppu_pipe.sv | 144 ++++++++++++++
 tb/tb_ppu_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_pipe.sv
// Two-stage post-processing pipe: lane mask, ReLU, arithmetic-shift requant, zero-point, clamp.
// Define PPU_ROUND_EN to add round-half-up before the shift; default build floors.
module ppu_pipe #(
    parameter int unsigned LANES = 2,
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned SF_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*IN_W-1:0] in_data,
    input  logic [LANES-1:0]      in_lane_en,
    input  logic [SF_W-1:0]       scaling_factor,
    input  logic [OUT_W-1:0]      zero_point,
    input  logic                  relu_en,
    input  logic                  need_ppu,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*IN_W-1:0] out_data,
    output logic [15:0]           sat_cnt,
    input  logic                  sat_clr
);
    localparam int unsigned YW = IN_W + 1;
    localparam int unsigned ZW = IN_W + 2;
    localparam int unsigned CW = $clog2(LANES + 1);

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_bypass_q, s1_bypass_d;
    logic [LANES*YW-1:0]   s1_y_q, s1_y_d;
    logic [OUT_W-1:0]      s1_zp_q, s1_zp_d;
    logic                  out_valid_q, out_valid_d;
    logic [LANES*IN_W-1:0] out_data_q, out_data_d;
    logic [CW-1:0]         s2_nflag_q, s2_nflag_d;
    logic [15:0]           sat_cnt_q, sat_cnt_d;

    logic                  s2_load;
    logic                  in_fire;
    logic signed [YW-1:0]  s1_x;
    int unsigned           s1_sh;
    logic signed [YW-1:0]  s2_y;
    logic signed [ZW-1:0]  s2_z;
    logic [OUT_W-1:0]      s2_res;
    logic [16:0]           sat_sum;

    assign s2_load  = !out_valid_q || out_ready;
    assign in_ready = !rst && (!s1_valid_q || s2_load);
    assign in_fire  = in_valid && in_ready;

    // Bypass beats park the raw lane (sign-extended) in the y field.
    always_comb begin : s1_comb
        s1_valid_d  = in_ready ? in_valid : s1_valid_q;
        s1_bypass_d = s1_bypass_q;
        s1_y_d      = s1_y_q;
        s1_zp_d     = s1_zp_q;
        s1_x        = '0;
        s1_sh       = 32'(scaling_factor);
        // Shifts beyond IN_W give the same sign fill as IN_W.
        if (s1_sh > IN_W) s1_sh = IN_W;
        if (in_fire) begin
            s1_bypass_d = !need_ppu;
            s1_zp_d     = zero_point;
            for (int k = 0; k < LANES; k++) begin
                s1_x = {in_data[k*IN_W+IN_W-1], in_data[k*IN_W +: IN_W]};
                if (!need_ppu) begin
                    s1_y_d[k*YW +: YW] = s1_x;
                end else begin
                    if (!in_lane_en[k] || (relu_en && s1_x[YW-1])) s1_x = '0;
`ifdef PPU_ROUND_EN
                    if (s1_sh != 0) s1_x = s1_x + (YW'(1) << (s1_sh - 1));
`endif
                    s1_y_d[k*YW +: YW] = s1_x >>> s1_sh;
                end
            end
        end
    end

    always_comb begin : s2_comb
        out_valid_d = s2_load ? s1_valid_q : out_valid_q;
        out_data_d  = out_data_q;
        s2_nflag_d  = s2_nflag_q;
        s2_y        = '0;
        s2_z        = '0;
        s2_res      = '0;
        if (s2_load && s1_valid_q) begin
            s2_nflag_d = '0;
            for (int k = 0; k < LANES; k++) begin
                s2_y = s1_y_q[k*YW +: YW];
                if (s1_bypass_q) begin
                    out_data_d[k*IN_W +: IN_W] = s2_y[IN_W-1:0];
                end else begin
                    s2_z = {s2_y[YW-1], s2_y} + {{(ZW-OUT_W){1'b0}}, s1_zp_q};
                    if (s2_z[ZW-1]) begin
                        s2_res     = '0;
                        s2_nflag_d = s2_nflag_d + CW'(1);
                    end else if (|s2_z[ZW-2:OUT_W]) begin
                        s2_res     = '1;
                        s2_nflag_d = s2_nflag_d + CW'(1);
                    end else begin
                        s2_res = s2_z[OUT_W-1:0];
                    end
                    out_data_d[k*IN_W +: IN_W] = {{(IN_W-OUT_W){1'b0}}, s2_res};
                end
            end
        end
    end

    always_comb begin : sat_comb
        sat_sum   = {1'b0, sat_cnt_q} + 17'(s2_nflag_q);
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (out_valid_q && out_ready) begin
            sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_bypass_q <= 1'b0;
            s1_y_q      <= '0;
            s1_zp_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            s2_nflag_q  <= '0;
            sat_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_bypass_q <= s1_bypass_d;
            s1_y_q      <= s1_y_d;
            s1_zp_q     <= s1_zp_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            s2_nflag_q  <= s2_nflag_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_cnt   = sat_cnt_q;
endmodule

// File: tb/tb_ppu_pipe.sv
// Directed self-checking bench for ppu_pipe (LANES=2, IN_W=16, OUT_W=8, SF_W=6).
module tb_ppu_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_lane_en = '0;
    logic [5:0]  scaling_factor = '0;
    logic [7:0]  zero_point = '0;
    logic        relu_en = 1'b0;
    logic        need_ppu = 1'b1;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [15:0] sat_cnt;
    logic        sat_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    ppu_pipe #(.LANES(2), .IN_W(16), .OUT_W(8), .SF_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_lane_en(in_lane_en), .scaling_factor(scaling_factor), .zero_point(zero_point),
        .relu_en(relu_en), .need_ppu(need_ppu), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [1:0] en, input logic [5:0] sf,
                         input logic [7:0] zp, input logic relu, input logic ppu);
        in_valid       = 1'b1;
        in_data        = d;
        in_lane_en     = en;
        scaling_factor = sf;
        zero_point     = zp;
        relu_en        = relu;
        need_ppu       = ppu;
    endtask

    // Single beat into an empty pipe with out_ready=1; observes valid after 1 and 2 edges.
    task automatic one_beat(input logic [31:0] d, input logic [1:0] en, input logic [5:0] sf,
                            input logic [7:0] zp, input logic relu, input logic ppu,
                            output logic early_v, output logic late_v, output logic [31:0] got);
        drive(d, en, sf, zp, relu, ppu);
        step;
        in_valid = 1'b0;
        early_v  = out_valid;
        step;
        late_v   = out_valid;
        got      = out_data;
        step;
    endtask

    task automatic test_reset;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
        if (sat_cnt !== 16'h0) begin errors++; $display("FAIL reset_sat: got %h expected 0", sat_cnt); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        step;
        rst = 1'b0;
        step;
    endtask

    task automatic test_basic;
        logic ev, lv;
        logic [31:0] got;
        one_beat(32'h0100_FF00, 2'b11, 6'd2, 8'd128, 1'b0, 1'b1, ev, lv, got);
        checks += 3;
        if (ev !== 1'b0) begin errors++; $display("FAIL basic_latency_early: got %b expected 0", ev); end
        if (lv !== 1'b1) begin errors++; $display("FAIL basic_latency_valid: got %b expected 1", lv); end
        if (got !== 32'h00C0_0040) begin errors++; $display("FAIL basic_requant: got %h expected 00c00040", got); end
        one_beat(32'h0100_FF00, 2'b11, 6'd2, 8'd128, 1'b1, 1'b1, ev, lv, got);
        checks += 2;
        if (got !== 32'h00C0_0080) begin errors++; $display("FAIL basic_relu: got %h expected 00c00080", got); end
        if (sat_cnt !== 16'd0) begin errors++; $display("FAIL basic_no_sat: got %0d expected 0", sat_cnt); end
    endtask

    task automatic test_saturation;
        logic ev, lv;
        logic [31:0] got;
        one_beat(32'h7FFF_8000, 2'b11, 6'd0, 8'd128, 1'b0, 1'b1, ev, lv, got);
        checks += 2;
        if (got !== 32'h00FF_0000) begin errors++; $display("FAIL sat_clamp: got %h expected 00ff0000", got); end
        if (sat_cnt !== 16'd2) begin errors++; $display("FAIL sat_count: got %0d expected 2", sat_cnt); end
        drive(32'h7FFF_8000, 2'b11, 6'd0, 8'd128, 1'b0, 1'b1);
        step;
        in_valid = 1'b0;
        step;
        checks += 1;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_clr_setup: got %b expected 1", out_valid); end
        sat_clr = 1'b1;
        step;
        sat_clr = 1'b0;
        checks += 1;
        if (sat_cnt !== 16'd0) begin errors++; $display("FAIL sat_clr_wins: got %0d expected 0", sat_cnt); end
    endtask

    task automatic test_mask_bypass;
        logic ev, lv;
        logic [31:0] got;
        one_beat(32'h1234_5678, 2'b01, 6'd4, 8'd128, 1'b0, 1'b1, ev, lv, got);
        checks += 2;
        if (got !== 32'h0080_00FF) begin errors++; $display("FAIL mask: got %h expected 008000ff", got); end
        if (sat_cnt !== 16'd1) begin errors++; $display("FAIL mask_sat: got %0d expected 1", sat_cnt); end
        one_beat(32'h1234_5678, 2'b00, 6'd4, 8'd128, 1'b1, 1'b0, ev, lv, got);
        checks += 2;
        if (got !== 32'h1234_5678) begin errors++; $display("FAIL bypass: got %h expected 12345678", got); end
        if (sat_cnt !== 16'd1) begin errors++; $display("FAIL bypass_sat: got %0d expected 1", sat_cnt); end
    endtask

    task automatic test_rounding;
        logic ev, lv;
        logic [31:0] got;
        logic [31:0] exp;
`ifdef PPU_ROUND_EN
        exp = 32'h007F_0082;
`else
        exp = 32'h007E_0081;
`endif
        one_beat(32'hFFFA_0006, 2'b11, 6'd2, 8'd128, 1'b0, 1'b1, ev, lv, got);
        checks += 1;
        if (got !== exp) begin errors++; $display("FAIL rounding: got %h expected %h", got, exp); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] beat[5];
        int sent, recv;
        logic held_v, saw_full, acc, emit;
        logic [31:0] held_d;
        for (int i = 0; i < 5; i++) beat[i] = {16'(20 + i), 16'(10 + i)};
        sent = 0; recv = 0; held_v = 1'b0; held_d = '0; saw_full = 1'b0;
        for (int c = 0; c < 40 && recv < 5; c++) begin
            out_ready = !(c >= 2 && c <= 5);
            if (sent < 5) drive(beat[sent], 2'b11, 6'd0, 8'd0, 1'b0, 1'b1);
            else in_valid = 1'b0;
            #1;
            checks++;
            if (in_ready !== ((sent - recv) < 2 || out_ready)) begin
                errors++;
                $display("FAIL bp_in_ready c=%0d: got %b held=%0d", c, in_ready, sent - recv);
            end
            if (!in_ready) saw_full = 1'b1;
            if (held_v) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_d) begin
                    errors++;
                    $display("FAIL bp_stable c=%0d: got %b/%h expected 1/%h", c, out_valid, out_data, held_d);
                end
            end
            acc  = in_valid && in_ready;
            emit = out_valid && out_ready;
            if (emit) begin
                checks++;
                if (recv >= 5 || out_data !== beat[recv % 5]) begin
                    errors++;
                    $display("FAIL bp_order beat=%0d: got %h expected %h", recv, out_data, beat[recv % 5]);
                end
                recv++;
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks += 2;
        if (recv != 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", recv); end
        if (!saw_full) begin errors++; $display("FAIL bp_in_ready_drop: got never-low expected low"); end
        for (int c = 0; c < 3; c++) begin
            step;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", out_valid); end
        end
    endtask

    task automatic test_reset_midstream;
        logic ev, lv;
        logic [31:0] got;
        logic stale;
        out_ready = 1'b0;
        drive(32'h0001_0002, 2'b11, 6'd0, 8'd0, 1'b0, 1'b0);
        step;
        drive(32'h0003_0004, 2'b11, 6'd0, 8'd0, 1'b0, 1'b0);
        step;
        in_valid = 1'b0;
        checks += 1;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_setup: got %b/%b expected 1/0", out_valid, in_ready);
        end
        rst = 1'b1;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        if (out_data !== 32'h0) begin errors++; $display("FAIL rst_mid_data: got %h expected 0", out_data); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 0", in_ready); end
        if (sat_cnt !== 16'h0) begin errors++; $display("FAIL rst_mid_sat: got %0d expected 0", sat_cnt); end
        step;
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step;
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        checks += 1;
        if (stale) begin errors++; $display("FAIL rst_mid_stale: got stale beat expected none"); end
        one_beat(32'hCAFE_BEEF, 2'b11, 6'd0, 8'd0, 1'b0, 1'b0, ev, lv, got);
        checks += 3;
        if (ev !== 1'b0) begin errors++; $display("FAIL rst_mid_early: got %b expected 0", ev); end
        if (lv !== 1'b1) begin errors++; $display("FAIL rst_mid_latency: got %b expected 1", lv); end
        if (got !== 32'hCAFE_BEEF) begin errors++; $display("FAIL rst_mid_data_after: got %h expected cafebeef", got); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_saturation;
        test_mask_bypass;
        test_rounding;
        test_back_to_back;
        test_reset_midstream;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
